// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle unsigned multiply/divide unit that sits beside
// the execute-stage ALU. Radix-2 shift-add multiplier, restoring divider.
// Build option: define MULDIV_DIV_EN to compile in the divider and DIV state;
// without it DIVU/REMU complete in one cycle with illegalM=1 and resultM=0.

`ifndef WORD
`define WORD 32
`endif

module muldiv_sequencer #(
    parameter int WIDTH = `WORD
) (
    input  logic             clk,
    input  logic             reset,     // asynchronous, active-low
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] src1E,
    input  logic [WIDTH-1:0] src2E,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             doneM,
    output logic [WIDTH-1:0] resultM,
    output logic             illegalM
);

    localparam int             CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH);

`ifdef MULDIV_DIV_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2, S_DIV = 2'd3} state_e;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_e;
`endif

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               res_sel_q, res_sel_d;    // 1: MULHU high half / REMU remainder
    logic [2*WIDTH-1:0] acc_q, acc_d;            // {partial product, multiplier}
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               illegal_q, illegal_d;

    // One shift-add step: add multiplicand into upper half when multiplier LSB is set.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;

    // One restoring step: shift {rem, quot} left, trial-subtract, keep if non-negative.
    logic [WIDTH+1:0] div_shift, div_trial;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quot_next;
    always_comb begin
        div_shift = {rem_q, quot_q[WIDTH-1]};
        div_trial = div_shift - {2'b00, divisor_q};
        if (!div_trial[WIDTH+1]) begin
            rem_next  = div_trial[WIDTH:0];
            quot_next = {quot_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_next  = div_shift[WIDTH:0];
            quot_next = {quot_q[WIDTH-2:0], 1'b0};
        end
    end
`endif

    // Next-state, datapath updates and registered-output values.
    always_comb begin
        // NOTE: every variable gets its default first so no path leaves one unassigned,
        // which would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        res_sel_d = res_sel_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        done_d    = 1'b0;
        result_d  = '0;
        illegal_d = 1'b0;
`ifdef MULDIV_DIV_EN
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (startE && !flush) begin
                    res_sel_d = opE[0];
                    cnt_d     = CNT_LOAD;
                    if (!opE[1]) begin
                        acc_d   = {{WIDTH{1'b0}}, src2E};
                        mcand_d = src1E;
                        state_d = S_MUL;
                    end else begin
`ifdef MULDIV_DIV_EN
                        if (src2E == '0) begin
                            // Divide by zero: quotient all ones, remainder is the dividend.
                            state_d  = S_DONE;
                            done_d   = 1'b1;
                            result_d = opE[0] ? src1E : '1;
                        end else begin
                            rem_d     = '0;
                            quot_d    = src1E;
                            divisor_d = src2E;
                            state_d   = S_DIV;
                        end
`else
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        illegal_d = 1'b1;
`endif
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = res_sel_q ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
                end
            end
`ifdef MULDIV_DIV_EN
            S_DIV: begin
                rem_d  = rem_next;
                quot_d = quot_next;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = res_sel_q ? rem_next[WIDTH-1:0] : quot_next;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Flush aborts whatever is in flight; the op never reports done.
        if (flush) begin
            state_d   = S_IDLE;
            done_d    = 1'b0;
            result_d  = '0;
            illegal_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            res_sel_q <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
            illegal_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            res_sel_q <= res_sel_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            done_q    <= done_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
`ifdef MULDIV_DIV_EN
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
`endif
        end
    end

    // Pipeline-facing outputs; result side comes straight from registers.
    always_comb begin
`ifdef MULDIV_DIV_EN
        busy = (state_q == S_MUL) || (state_q == S_DIV);
`else
        busy = (state_q == S_MUL);
`endif
        stall    = ((state_q == S_IDLE) && startE) || busy;
        doneM    = done_q;
        resultM  = result_q;
        illegalM = illegal_q;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer (WIDTH=32). Expectations follow the
// MULDIV_DIV_EN build option. Outputs are sampled on the falling clock edge.
`timescale 1ns/1ps

module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         startE;
    logic [1:0]   opE;
    logic [W-1:0] src1E;
    logic [W-1:0] src2E;
    logic         flush;
    logic         stall;
    logic         busy;
    logic         doneM;
    logic [W-1:0] resultM;
    logic         illegalM;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .startE   (startE),
        .opE      (opE),
        .src1E    (src1E),
        .src2E    (src2E),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .doneM    (doneM),
        .resultM  (resultM),
        .illegalM (illegalM)
    );

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ill;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] res, input logic ill,
                           input int lat);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.res = res; v.ill = ill; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Issue one op at a falling edge (cycle 0) and watch 40 cycles.
    // Stall must be high until the done cycle and low from then on.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output logic ill, output int lat,
                          output int pulses, output int stall_bad);
        res = '0; ill = 1'b0; lat = -1; pulses = 0; stall_bad = 0;
        startE = 1'b1; opE = op; src1E = a; src2E = b;
        #1;
        if (!stall) stall_bad++;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (doneM) begin
                pulses++;
                if (lat < 0) begin
                    lat = c; res = resultM; ill = illegalM;
                end
            end
            if ((lat < 0) != stall) stall_bad++;
            if (c == 1) startE = 1'b0;
        end
    endtask

    logic [W-1:0] res;
    logic         ill;
    int           lat, pulses, sbad;

    initial begin
        reset = 1'b0; startE = 1'b0; flush = 1'b0; opE = 2'b00; src1E = '0; src2E = '0;

        // Reset state
        #3;
        check("reset.stall",   32'(stall),    32'd0);
        check("reset.busy",    32'(busy),     32'd0);
        check("reset.doneM",   32'(doneM),    32'd0);
        check("reset.resultM", resultM,       32'd0);
        check("reset.illegal", 32'(illegalM), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;   // released mid-cycle

        add_vec("mul_7x6",       2'b00, 32'd7,          32'd6,          32'd42,         1'b0, 33);
        add_vec("mulhu_ff_ff",   2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0, 33);
        add_vec("mul_ff_ff",     2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  1'b0, 33);
        add_vec("mulhu_2p31x4",  2'b01, 32'h8000_0000,  32'd4,          32'd2,          1'b0, 33);
        add_vec("mul_2p16sq",    2'b00, 32'h0001_0000,  32'h0001_0000,  32'd0,          1'b0, 33);
        add_vec("mulhu_2p16sq",  2'b01, 32'h0001_0000,  32'h0001_0000,  32'd1,          1'b0, 33);
`ifdef MULDIV_DIV_EN
        add_vec("divu_100_7",    2'b10, 32'd100,        32'd7,          32'd14,         1'b0, 33);
        add_vec("remu_100_7",    2'b11, 32'd100,        32'd7,          32'd2,          1'b0, 33);
        add_vec("divu_5_0",      2'b10, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b0, 1);
        add_vec("remu_5_0",      2'b11, 32'd5,          32'd0,          32'd5,          1'b0, 1);
        add_vec("divu_max_1",    2'b10, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, 33);
        add_vec("remu_7_100",    2'b11, 32'd7,          32'd100,        32'd7,          1'b0, 33);
`else
        add_vec("divu_100_7",    2'b10, 32'd100,        32'd7,          32'd0,          1'b1, 1);
        add_vec("remu_100_7",    2'b11, 32'd100,        32'd7,          32'd0,          1'b1, 1);
        add_vec("divu_5_0",      2'b10, 32'd5,          32'd0,          32'd0,          1'b1, 1);
`endif

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, ill, lat, pulses, sbad);
            check({vecs[i].name, ".result"},  res,          vecs[i].res);
            check({vecs[i].name, ".illegal"}, 32'(ill),     32'(vecs[i].ill));
            check({vecs[i].name, ".latency"}, 32'(lat),     32'(vecs[i].lat));
            check({vecs[i].name, ".pulses"},  32'(pulses),  32'd1);
            check({vecs[i].name, ".stall"},   32'(sbad),    32'd0);
        end

        // Flush at cycle 10 of a MUL: back to IDLE, no doneM, then a fresh MUL works.
        startE = 1'b1; opE = 2'b00; src1E = 32'd5; src2E = 32'd5;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) startE = 1'b0;
        end
        check("flush.busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush.stall", 32'(stall), 32'd0);
        check("flush.busy",  32'(busy),  32'd0);
        check("flush.doneM", 32'(doneM), 32'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (doneM) pulses++;
        end
        check("flush.no_done", 32'(pulses), 32'd0);
        run_op(2'b00, 32'd3, 32'd3, res, ill, lat, pulses, sbad);
        check("after_flush.result",  res,          32'd9);
        check("after_flush.latency", 32'(lat),     32'd33);
        check("after_flush.pulses",  32'(pulses),  32'd1);

        // Flush together with startE in IDLE: request must not be accepted.
        startE = 1'b1; flush = 1'b1; opE = 2'b00; src1E = 32'd2; src2E = 32'd2;
        @(posedge clk);
        @(negedge clk);
        startE = 1'b0; flush = 1'b0;
        check("flush_start.busy", 32'(busy), 32'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (doneM) pulses++;
        end
        check("flush_start.no_done", 32'(pulses), 32'd0);

        // Asynchronous reset pulse at cycle 15 of a long op.
`ifdef MULDIV_DIV_EN
        startE = 1'b1; opE = 2'b10; src1E = 32'd100; src2E = 32'd7;
`else
        startE = 1'b1; opE = 2'b00; src1E = 32'd7;   src2E = 32'd6;
`endif
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) startE = 1'b0;
        end
        check("rst_mid.busy_before", 32'(busy), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("rst_mid.stall",   32'(stall),    32'd0);
        check("rst_mid.busy",    32'(busy),     32'd0);
        check("rst_mid.doneM",   32'(doneM),    32'd0);
        check("rst_mid.resultM", resultM,       32'd0);
        check("rst_mid.illegal", 32'(illegalM), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_op(2'b10, 32'd9, 32'd3, res, ill, lat, pulses, sbad);
`ifdef MULDIV_DIV_EN
        check("after_rst.result",  res,      32'd3);
        check("after_rst.illegal", 32'(ill), 32'd0);
        check("after_rst.latency", 32'(lat), 32'd33);
`else
        check("after_rst.result",  res,      32'd0);
        check("after_rst.illegal", 32'(ill), 32'd1);
        check("after_rst.latency", 32'(lat), 32'd1);
`endif
        check("after_rst.pulses", 32'(pulses), 32'd1);

        // startE toggled with other operands while busy: original result, one pulse.
        startE = 1'b1; opE = 2'b00; src1E = 32'd7; src2E = 32'd6;
        pulses = 0; lat = -1; res = '0;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (doneM) begin
                pulses++;
                if (lat < 0) begin
                    lat = c; res = resultM;
                end
            end
            if (c < 20) begin
                startE = c[0]; opE = 2'(c); src1E = 32'(c * 1000); src2E = 32'(c + 1);
            end else begin
                startE = 1'b0;
            end
        end
        check("toggle.result",  res,          32'd42);
        check("toggle.latency", 32'(lat),     32'd33);
        check("toggle.pulses",  32'(pulses),  32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
